// File: rtl/tft_pkg.sv
// Shared definitions for the TFT draw arbiter: command layout, colours, FSM states.
package tft_pkg;

  localparam int CMD_W = 80;

  // Field positions inside a packed rectangle command.
  localparam int COLOR_LSB = 64;
  localparam int XS_LSB    = 48;
  localparam int YS_LSB    = 32;
  localparam int XE_LSB    = 16;
  localparam int YE_LSB    = 0;

  // RGB565 colours that come up often.
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  // State encodings of the arbiter sequencer.
  localparam logic [2:0] ST_PWR_WAIT  = 3'd0;
  localparam logic [2:0] ST_INIT_WAIT = 3'd1;
  localparam logic [2:0] ST_IDLE      = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  typedef enum logic [2:0] {
    PWR_WAIT  = ST_PWR_WAIT,
    INIT_WAIT = ST_INIT_WAIT,
    IDLE      = ST_IDLE,
    ISSUE     = ST_ISSUE,
    WAIT_DONE = ST_WAIT_DONE
  } state_t;

  // Builds a rectangle command from its colour and corner coordinates.
  function automatic logic [CMD_W-1:0] make_cmd(input logic [15:0] color,
                                                 input logic [15:0] xs,
                                                 input logic [15:0] ys,
                                                 input logic [15:0] xe,
                                                 input logic [15:0] ye);
    logic [CMD_W-1:0] c;
    c = '0;
    c[COLOR_LSB +: 16] = color;
    c[XS_LSB +: 16]    = xs;
    c[YS_LSB +: 16]    = ys;
    c[XE_LSB +: 16]    = xe;
    c[YE_LSB +: 16]    = ye;
    return c;
  endfunction

endpackage

// File: rtl/tft_draw_arb_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Walk the requesters starting at ptr; the first one found valid wins.
  always_comb begin
    logic [IDX_W:0] cand;
    cand  = '0;
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NREQ)) begin
        cand = cand - (IDX_W + 1)'(NREQ);
      end
      if (!any && valid[cand[IDX_W-1:0]]) begin
        any                       = 1'b1;
        index                     = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tft_draw_arb.sv
// Shares one tft_ctrl between several draw producers: panel bring-up, then
// round-robin grants of one rectangle command each, held until the controller finishes.
module tft_draw_arb #(
  parameter int NREQ      = 2,
  parameter int CMD_W     = 80,
  parameter int PWR_DLY_W = 16,
  parameter int TMO_W     = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       req_done,
  output logic                  tft_init,
  output logic                  tft_draw,
  input  logic                  tft_busy,
  input  logic                  tft_done,
  output logic [CMD_W-1:0]      tft_cmd,
  output logic                  ready,
  output logic                  tmo_err
);
  import tft_pkg::*;

  localparam int IDX_W = $clog2(NREQ);
  // Last counter value before the wait is declared lost: 2^TMO_W-1 waiting cycles in total.
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

  state_t              state;
  logic [PWR_DLY_W-1:0] pwr_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    next_ptr;
  logic [NREQ-1:0]     pick_grant;
  logic                pick_any;
  logic                accept;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_idx),
    .any   (pick_any)
  );

  // A grant is only offered from IDLE while the controller is free; the ready
  // acknowledge is combinational so the producer sees it in the accepting cycle.
  assign accept    = (state == IDLE) && !tft_busy && pick_any;
  assign req_ready = accept ? pick_grant : '0;
  assign next_ptr  = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  // Bring-up sequencing, grant latching and completion tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWR_WAIT;
      pwr_cnt   <= '0;
      tmo_cnt   <= '0;
      rr_ptr    <= '0;
      grant_idx <= '0;
      tft_cmd   <= '0;
      tft_init  <= 1'b0;
      tft_draw  <= 1'b0;
      req_done  <= '0;
      ready     <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      tft_init <= 1'b0;
      tft_draw <= 1'b0;
      req_done <= '0;
      case (state)
        PWR_WAIT: begin
          if (pwr_cnt == '1) begin
            tft_init <= 1'b1;
            state    <= INIT_WAIT;
          end else begin
            pwr_cnt <= pwr_cnt + PWR_DLY_W'(1);
          end
        end
        INIT_WAIT: begin
          if (tft_done) begin
            ready   <= 1'b1;
            tmo_cnt <= '0;
            state   <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_err <= 1'b1;
            ready   <= 1'b1;
            tmo_cnt <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            tft_cmd   <= req_cmd[pick_idx*CMD_W +: CMD_W];
            grant_idx <= pick_idx;
            rr_ptr    <= next_ptr;
            tft_draw  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tft_done || (tmo_cnt == TMO_LAST)) begin
            if (!tft_done) begin
              tmo_err <= 1'b1;
            end
            req_done[grant_idx] <= 1'b1;
            tmo_cnt             <= '0;
            state               <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          state <= PWR_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_draw_arb.sv
// Self-checking bench for tft_draw_arb with three requesters and short delay/timeout counters.
module tb_tft_draw_arb;
  import tft_pkg::*;

  localparam int N  = 3;
  localparam int CW = CMD_W;
  localparam int PW = 4;
  localparam int TW = 6;
  // tft_init appears after the 2^PW-th clock edge following reset release.
  localparam int INIT_EDGE = (1 << PW);
  // 2^TW-1 silent cycles in WAIT_DONE, flagged on the following edge (counted from the draw cycle).
  localparam int TMO_EDGE = (1 << TW);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*CW-1:0] req_cmd;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_done;
  logic            tft_init;
  logic            tft_draw;
  logic            tft_busy;
  logic            tft_done;
  logic [CW-1:0]   tft_cmd;
  logic            ready;
  logic            tmo_err;

  int checks = 0;
  int errors = 0;
  int rr_model = 0;
  logic [CW-1:0] cmds [N];

  always #5 clk = ~clk;

  tft_draw_arb #(
    .NREQ      (N),
    .CMD_W     (CW),
    .PWR_DLY_W (PW),
    .TMO_W     (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ready (req_ready),
    .req_done  (req_done),
    .tft_init  (tft_init),
    .tft_draw  (tft_draw),
    .tft_busy  (tft_busy),
    .tft_done  (tft_done),
    .tft_cmd   (tft_cmd),
    .ready     (ready),
    .tmo_err   (tmo_err)
  );

  // Reference arbitration rule: first valid index scanning from the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = i;
        c++;
      end
    end
    return (c == 1) ? r : -2;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_cmds();
    for (int i = 0; i < N; i++) req_cmd[i*CW +: CW] = cmds[i];
  endtask

  task automatic rand_cmds();
    for (int i = 0; i < N; i++) begin
      cmds[i] = make_cmd(16'($urandom()), 16'($urandom()), 16'($urandom()),
                         16'($urandom()), 16'($urandom()));
    end
    drive_cmds();
  endtask

  // Waits (bounded) for a one-hot accept; idx is -1 on timeout, -2 if not one-hot.
  task automatic wait_accept(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (req_ready != '0) begin
        idx = onehot_idx(req_ready);
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; tft_busy = 1'b0; tft_done = 1'b0;
    rand_cmds();
    step(); step(); #1;
    checks++;
    if ({req_ready, req_done, tft_init, tft_draw, ready, tmo_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0", {req_ready, req_done, tft_init, tft_draw, ready, tmo_err});
    end
    checks++;
    if (tft_cmd !== '0) begin
      errors++; $display("[TB] FAIL reset_cmd: got %h expected 0", tft_cmd);
    end
    rst_n = 1'b1; rr_model = 0;
    for (int j = 1; j <= INIT_EDGE + 4; j++) begin
      step(); #1;
      checks++;
      if (tft_init !== (j == INIT_EDGE)) begin
        errors++; $display("[TB] FAIL init_pulse edge %0d: got %b expected %b", j, tft_init, (j == INIT_EDGE));
      end
      checks++;
      if (req_ready !== '0 || ready !== 1'b0) begin
        errors++; $display("[TB] FAIL early_ready edge %0d: got req_ready=%b ready=%b expected 0", j, req_ready, ready);
      end
      if (j == INIT_EDGE + 4) begin
        req_valid = '0; tft_done = 1'b1;
      end
    end
    step(); tft_done = 1'b0; #1;
    checks++;
    if (ready !== 1'b1 || tmo_err !== 1'b0) begin
      errors++; $display("[TB] FAIL init_done: got ready=%b tmo_err=%b expected 1/0", ready, tmo_err);
    end
  endtask

  task automatic test_single();
    logic [CW-1:0] exp_cmd;
    exp_cmd = make_cmd(WHITE, 16'd0, 16'd0, 16'd239, 16'd319);
    cmds[0] = exp_cmd; drive_cmds();
    req_valid = 3'b001; #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("[TB] FAIL single_accept: got %b expected 001", req_ready);
    end
    rr_model = 1;
    step(); #1;
    checks++;
    if (tft_draw !== 1'b1 || tft_cmd !== exp_cmd || req_ready !== '0) begin
      errors++; $display("[TB] FAIL single_draw: got draw=%b cmd=%h ready=%b expected 1 %h 000", tft_draw, tft_cmd, req_ready, exp_cmd);
    end
    step(); #1;
    checks++;
    if (tft_draw !== 1'b0) begin
      errors++; $display("[TB] FAIL single_draw_len: got %b expected 0", tft_draw);
    end
    req_valid = '0;
    step(); tft_done = 1'b1; step(); tft_done = 1'b0; #1;
    checks++;
    if (req_done !== 3'b001) begin
      errors++; $display("[TB] FAIL single_done: got %b expected 001", req_done);
    end
    step(); #1;
    checks++;
    if (req_done !== '0) begin
      errors++; $display("[TB] FAIL single_done_len: got %b expected 000", req_done);
    end
  endtask

  task automatic test_round_robin();
    int idx, exp, prev;
    logic [CW-1:0] exp_cmd;
    prev = -1;
    rand_cmds();
    req_valid = '1;
    for (int t = 0; t < 6; t++) begin
      exp = model_pick(req_valid, rr_model);
      wait_accept(4, idx);
      checks++;
      if (idx !== exp || idx == prev) begin
        errors++; $display("[TB] FAIL rr_grant %0d: got %0d expected %0d (prev %0d)", t, idx, exp, prev);
      end
      prev = exp; rr_model = (exp + 1) % N; exp_cmd = cmds[exp];
      step();
      cmds[exp] = make_cmd(16'($urandom()), 16'($urandom()), 16'd1, 16'd2, 16'd3);
      drive_cmds(); #1;
      checks++;
      if (tft_draw !== 1'b1 || tft_cmd !== exp_cmd) begin
        errors++; $display("[TB] FAIL rr_draw %0d: got draw=%b cmd=%h expected 1 %h", t, tft_draw, tft_cmd, exp_cmd);
      end
      step(); step(); step();
      tft_done = 1'b1; step(); tft_done = 1'b0; #1;
      checks++;
      if (req_done !== N'(1 << exp)) begin
        errors++; $display("[TB] FAIL rr_done %0d: got %b expected one-hot %0d", t, req_done, exp);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_busy_hold();
    int idx;
    logic [CW-1:0] exp_cmd;
    rand_cmds();
    tft_busy = 1'b1; req_valid = 3'b010;
    for (int b = 0; b < 4; b++) begin
      #1;
      checks++;
      if (req_ready !== '0) begin
        errors++; $display("[TB] FAIL busy_block %0d: got %b expected 000", b, req_ready);
      end
      step();
    end
    tft_busy = 1'b0;
    wait_accept(1, idx);
    checks++;
    if (idx !== model_pick(3'b010, rr_model)) begin
      errors++; $display("[TB] FAIL busy_grant: got %0d expected 1", idx);
    end
    rr_model = 2; exp_cmd = cmds[1];
    step();
    req_valid = '0; cmds[1] = ~exp_cmd; drive_cmds(); tft_busy = 1'b1; #1;
    checks++;
    if (tft_draw !== 1'b1 || tft_cmd !== exp_cmd) begin
      errors++; $display("[TB] FAIL hold_draw: got draw=%b cmd=%h expected 1 %h", tft_draw, tft_cmd, exp_cmd);
    end
    for (int c = 0; c < 5; c++) begin
      step(); rand_cmds(); #1;
      checks++;
      if (tft_cmd !== exp_cmd) begin
        errors++; $display("[TB] FAIL hold_cmd %0d: got %h expected %h", c, tft_cmd, exp_cmd);
      end
    end
    tft_busy = 1'b0; tft_done = 1'b1; step(); tft_done = 1'b0; #1;
    checks++;
    if (req_done !== 3'b010 || tft_cmd !== exp_cmd) begin
      errors++; $display("[TB] FAIL hold_done: got done=%b cmd=%h expected 010 %h", req_done, tft_cmd, exp_cmd);
    end
  endtask

  task automatic test_random();
    int idx, exp, busy_cyc, delay;
    logic [CW-1:0] exp_cmd;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        tft_done = 1'b1; step(); tft_done = 1'b0; #1;
        checks++;
        if (req_done !== '0 || ready !== 1'b1) begin
          errors++; $display("[TB] FAIL idle_done_ignored %0d: got done=%b ready=%b expected 000 1", t, req_done, ready);
        end
      end
      rand_cmds();
      busy_cyc = $urandom_range(0, 2);
      tft_busy = (busy_cyc != 0);
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int b = 0; b < busy_cyc; b++) begin
        #1;
        checks++;
        if (req_ready !== '0) begin
          errors++; $display("[TB] FAIL rand_busy %0d: got %b expected 000", t, req_ready);
        end
        step();
        req_valid = N'($urandom_range(0, (1 << N) - 1));
      end
      tft_busy = 1'b0;
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      exp = model_pick(req_valid, rr_model);
      wait_accept(1, idx);
      checks++;
      if (idx !== exp) begin
        errors++; $display("[TB] FAIL rand_grant %0d: got %0d expected %0d (valid %b)", t, idx, exp, req_valid);
      end
      rr_model = (exp + 1) % N; exp_cmd = cmds[exp];
      step();
      req_valid = '0; tft_done = 1'($urandom_range(0, 1)); #1;
      checks++;
      if (tft_draw !== 1'b1 || tft_cmd !== exp_cmd) begin
        errors++; $display("[TB] FAIL rand_draw %0d: got draw=%b cmd=%h expected 1 %h", t, tft_draw, tft_cmd, exp_cmd);
      end
      delay = $urandom_range(1, 4);
      step(); tft_done = 1'b0; #1;
      checks++;
      if (req_done !== '0) begin
        errors++; $display("[TB] FAIL rand_draw_done_ignored %0d: got %b expected 000", t, req_done);
      end
      for (int d = 1; d < delay; d++) step();
      tft_done = 1'b1; step(); tft_done = 1'b0; #1;
      checks++;
      if (req_done !== N'(1 << exp) || tmo_err !== 1'b0) begin
        errors++; $display("[TB] FAIL rand_done %0d: got done=%b tmo=%b expected one-hot %0d tmo 0", t, req_done, tmo_err, exp);
      end
      step(); #1;
      checks++;
      if (req_done !== '0) begin
        errors++; $display("[TB] FAIL rand_done_len %0d: got %b expected 000", t, req_done);
      end
    end
  endtask

  task automatic test_timeout();
    int idx, exp;
    rand_cmds();
    req_valid = 3'b001;
    exp = model_pick(req_valid, rr_model);
    wait_accept(1, idx);
    checks++;
    if (idx !== exp) begin
      errors++; $display("[TB] FAIL tmo_grant: got %0d expected %0d", idx, exp);
    end
    rr_model = (exp + 1) % N;
    step(); req_valid = '0;
    for (int j = 1; j <= TMO_EDGE + 4; j++) begin
      step(); #1;
      checks++;
      if (tmo_err !== (j >= TMO_EDGE) || req_done !== ((j == TMO_EDGE) ? N'(1 << exp) : N'(0))) begin
        errors++; $display("[TB] FAIL tmo_expiry edge %0d: got tmo=%b done=%b expected %b", j, tmo_err, req_done, (j >= TMO_EDGE));
      end
    end
    req_valid = 3'b100;
    exp = model_pick(req_valid, rr_model);
    wait_accept(1, idx);
    checks++;
    if (idx !== exp) begin
      errors++; $display("[TB] FAIL tmo_next_grant: got %0d expected %0d", idx, exp);
    end
    rr_model = (exp + 1) % N;
    step(); req_valid = '0; step();
    tft_done = 1'b1; step(); tft_done = 1'b0; #1;
    checks++;
    if (req_done !== N'(1 << exp) || tmo_err !== 1'b1 || ready !== 1'b1) begin
      errors++; $display("[TB] FAIL tmo_sticky: got done=%b tmo=%b ready=%b expected one-hot %0d 1 1", req_done, tmo_err, ready, exp);
    end
  endtask

  task automatic test_async_reset();
    int idx, exp;
    rand_cmds();
    req_valid = 3'b010;
    exp = model_pick(req_valid, rr_model);
    wait_accept(1, idx);
    checks++;
    if (idx !== exp) begin
      errors++; $display("[TB] FAIL ar_grant: got %0d expected %0d", idx, exp);
    end
    step(); req_valid = '0; step(); step();
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({req_ready, req_done, tft_init, tft_draw, ready, tmo_err} !== '0 || tft_cmd !== '0) begin
      errors++;
      $display("[TB] FAIL ar_immediate: got flags=%b cmd=%h expected 0", {req_ready, req_done, tft_init, tft_draw, ready, tmo_err}, tft_cmd);
    end
    req_valid = '1;
    step(); step(); rst_n = 1'b1; rr_model = 0;
    for (int j = 1; j <= INIT_EDGE + 4; j++) begin
      step(); #1;
      checks++;
      if (tft_init !== (j == INIT_EDGE) || req_done !== '0 || req_ready !== '0) begin
        errors++; $display("[TB] FAIL ar_restart edge %0d: got init=%b done=%b ready=%b", j, tft_init, req_done, req_ready);
      end
      if (j == INIT_EDGE + 4) begin
        req_valid = '0; tft_done = 1'b1;
      end
    end
    step(); tft_done = 1'b0; #1;
    checks++;
    if (ready !== 1'b1 || tmo_err !== 1'b0) begin
      errors++; $display("[TB] FAIL ar_ready: got ready=%b tmo=%b expected 1 0", ready, tmo_err);
    end
    req_valid = 3'b011;
    exp = model_pick(req_valid, rr_model);
    wait_accept(1, idx);
    checks++;
    if (idx !== exp) begin
      errors++; $display("[TB] FAIL ar_ptr_reset: got %0d expected %0d", idx, exp);
    end
    step(); req_valid = '0; step();
    tft_done = 1'b1; step(); tft_done = 1'b0; #1;
    checks++;
    if (req_done !== N'(1 << exp)) begin
      errors++; $display("[TB] FAIL ar_done: got %b expected one-hot %0d", req_done, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    req_valid = '0; req_cmd = '0; tft_busy = 1'b0; tft_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy_hold();
    test_random();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
